alu_seq: RTL and testbench

Parametrised, registered ALU for the HC4 datapath. Extends the 8-bit combinational ALU to any operand width and adds shift operations, an iterative shift-and-add multiplier, a zero flag, and a start/busy/done handshake. Results and flags are registered. The block sits between the register file and the accumulator write-back and is driven by the sequencer.

---
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: parametrised registered ALU for the HC4 datapath.
//
// Single-cycle ops (logic, add/sub, shifts) are computed and registered on
// the accepting edge. Unsigned multiply runs as a WIDTH-iteration
// shift-and-add sequence. Results and flags hold until the next completion.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0. Completion is signalled by a one-cycle done pulse, and out,
// carry_out and zero_out update in that same cycle. start seen while
// busy=1 is dropped. busy and done are never high together.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset, priority over start
//   start      request, sampled only when busy=0
//   in_A/in_B  operands, latched on accept
//   sel_in     operation select (4 bits), latched on accept
//   carry_in   carry / shift-in, latched on accept
//   out        registered result
//   carry_out  registered carry / overflow flag
//   zero_out   registered flag, out == 0
//   busy       multiply in progress
//   done       one-cycle completion pulse
//   state_o    FSM state for debug observation (0 = IDLE, 1 = MUL)
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [3:0]       sel_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             zero_out,
    output logic             busy,
    output logic             done,
    output logic [0:0]       state_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]         state_q,  state_d;
    logic [WIDTH-1:0]   out_q,    out_d;
    logic               carry_q,  carry_d;
    logic               zero_q,   zero_d;
    logic               done_q,   done_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q,    cnt_d;

    logic               is_mul;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     sum_w;
    logic [2*WIDTH-1:0] acc_sum;
    logic               last_iter;

    // Single-cycle result from the live inputs; only used on an accepting edge.
    always_comb begin
        is_mul  = MUL_EN && (sel_in == 4'b1010);
        alu_res = '0;
        alu_c   = 1'b0;
        sum_w   = '0;
        case (sel_in)
            4'b0000: alu_res = in_A;
            4'b0001: alu_res = in_A & in_B;
            4'b0010: alu_res = in_A | in_B;
            4'b0011: alu_res = in_A ^ in_B;
            4'b0100: alu_res = in_B;
            4'b0101: sum_w = {1'b0, in_A} + {1'b0, in_B} + {{WIDTH{1'b0}}, carry_in};
            4'b0110: sum_w = {1'b0, ~in_A} + {1'b0, in_B} + {{WIDTH{1'b0}}, carry_in};
            4'b0111: sum_w = {1'b0, in_A} + {1'b0, ~in_B} + {{WIDTH{1'b0}}, carry_in};
            4'b1000: begin
                alu_res = {in_A[WIDTH-2:0], carry_in};
                alu_c   = in_A[WIDTH-1];
            end
            4'b1001: begin
                alu_res = {carry_in, in_A[WIDTH-1:1]};
                alu_c   = in_A[0];
            end
            default: begin
                // Reserved codes (and 1010 when the multiplier is absent).
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
        if (sel_in == 4'b0101 || sel_in == 4'b0110 || sel_in == 4'b0111) begin
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
        end
    end

    // One shift-and-add step; the final step's sum is the full product.
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, in_A};
                        mplier_d = in_B;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else begin
                        out_d   = alu_res;
                        carry_d = alu_c;
                        zero_d  = (alu_res == '0);
                        done_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    out_d   = acc_sum[WIDTH-1:0];
                    carry_d = |acc_sum[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_sum[WIDTH-1:0] == '0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out       = out_q;
    assign carry_out = carry_q;
    assign zero_out  = zero_q;
    assign done      = done_q;
    assign busy      = (state_q == ST_MUL);
    assign state_o   = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: one WIDTH=8 instance with the multiplier and one
// WIDTH=16 instance without it. Drivers push expected {carry, zero, out}
// into per-instance queues; monitors pop and compare on every done pulse.
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=8, MUL_EN=1
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] sel8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] out8;
    logic       c8, z8, busy8, done8;
    logic [0:0] st8;

    // WIDTH=16, MUL_EN=0
    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0]  sel16 = '0;
    logic        cin16 = 1'b0;
    logic [15:0] out16;
    logic        c16, z16, busy16, done16;
    logic [0:0]  st16;

    logic [9:0]  exp_q8[$];
    logic [17:0] exp_q16[$];

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .in_A(a8), .in_B(b8),
        .sel_in(sel8), .carry_in(cin8), .out(out8), .carry_out(c8),
        .zero_out(z8), .busy(busy8), .done(done8), .state_o(st8)
    );

    alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .in_A(a16), .in_B(b16),
        .sel_in(sel16), .carry_in(cin16), .out(out16), .carry_out(c16),
        .zero_out(z16), .busy(busy16), .done(done16), .state_o(st16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst && done8) begin
            chk("busy_done_excl8", {31'b0, busy8}, 32'd0);
            if (exp_q8.size() == 0) begin
                chk("unexpected_done8", 32'd1, 32'd0);
            end else begin
                logic [9:0] e;
                e = exp_q8.pop_front();
                chk("result8 {c,z,out}", {22'b0, c8, z8, out8}, {22'b0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done16) begin
            chk("busy16_low", {31'b0, busy16}, 32'd0);
            if (exp_q16.size() == 0) begin
                chk("unexpected_done16", 32'd1, 32'd0);
            end else begin
                logic [17:0] e;
                e = exp_q16.pop_front();
                chk("result16 {c,z,out}", {14'b0, c16, z16, out16}, {14'b0, e});
            end
        end
    end

    task automatic issue8(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] eo, input logic ec, input bit push);
        @(negedge clk);
        sel8 = sel; a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        if (push) exp_q8.push_back({ec, (eo == 8'h00), eo});
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = $urandom_range(0, 255);
        b8 = $urandom_range(0, 255);
    endtask

    task automatic issue16(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [15:0] eo, input logic ec);
        @(negedge clk);
        sel16 = sel; a16 = a; b16 = b; cin16 = cin; start16 = 1'b1;
        exp_q16.push_back({ec, (eo == 16'h0000), eo});
        @(posedge clk);
        #1;
        start16 = 1'b0;
    endtask

    // Multiply with busy/done timing checks; optional ignored start at cycle 3.
    task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eo, input logic ec, input bit extra);
        issue8(4'b1010, a, b, 1'b0, eo, ec, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mul_busy", {31'b0, busy8}, 32'd1);
            chk("mul_no_early_done", {31'b0, done8}, 32'd0);
            if (extra && i == 2) begin
                sel8 = 4'b0101; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
            end
            if (extra && i == 3) start8 = 1'b0;
        end
        @(negedge clk);
        chk("mul_busy_clear", {31'b0, busy8}, 32'd0);
        chk("mul_done_latency", {31'b0, done8}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out", {24'b0, out8}, 32'd0);
        chk("reset_flags", {28'b0, c8, z8, busy8, done8}, 32'd0);
        rst = 1'b0;

        // Back-to-back single-cycle ops.
        issue8(4'b0101, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b1);
        issue8(4'b0111, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b1);
        issue8(4'b1000, 8'h81, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1);
        issue8(4'b1001, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        issue8(4'b0001, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b1);
        issue8(4'b0010, 8'hA0, 8'h05, 1'b1, 8'hA5, 1'b0, 1'b1);
        issue8(4'b0011, 8'hFF, 8'h0F, 1'b1, 8'hF0, 1'b0, 1'b1);
        issue8(4'b0000, 8'h5A, 8'h11, 1'b1, 8'h5A, 1'b0, 1'b1);
        issue8(4'b0100, 8'h5A, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b1);
        issue8(4'b0110, 8'h03, 8'h10, 1'b1, 8'h0D, 1'b1, 1'b1);
        issue8(4'b0101, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
        issue8(4'b1100, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1);
        issue8(4'b1001, 8'h80, 8'h00, 1'b1, 8'hC0, 1'b0, 1'b1);

        // Multiplies.
        mul8(8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0);
        mul8(8'h10, 8'h20, 8'h00, 1'b1, 1'b1);
        mul8(8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
        repeat (4) @(negedge clk);

        // Reset during a multiply: no done, everything cleared.
        issue8(4'b0101, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b1);
        issue8(4'b1010, 8'h0D, 8'h0B, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mul_out", {24'b0, out8}, 32'd0);
        chk("rst_mul_flags", {28'b0, c8, z8, busy8, done8}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_mul_idle_busy", {31'b0, busy8}, 32'd0);

        // WIDTH=16 without multiplier.
        issue16(4'b0101, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        issue16(4'b0101, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        issue16(4'b1010, 16'h0003, 16'h0004, 1'b0, 16'h0000, 1'b0);
        issue16(4'b1000, 16'h8001, 16'h0000, 1'b0, 16'h0002, 1'b1);

        repeat (5) @(negedge clk);
        chk("exp_q8_drained", exp_q8.size(), 32'd0);
        chk("exp_q16_drained", exp_q16.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
